fetch_predecode_bundle: RTL

Parametrised fetch-stage predecoder for the superscalar front end. It accepts one fetch bundle of `LANES` instructions per cycle and classifies each lane as conditional branch, JAL or JALR. It extracts sign-extended immediates, applies static BTFN prediction, and truncates the bundle after the first predicted-taken lane. Results are held in a valid/ready pipeline register between fetch and decode, and a one-shot redirect is raised toward the PC generator.

---
 rtl/fetch_pkg.sv | 20 ++
 rtl/fetch_predecode_bundle_if.sv | 43 ++++
 rtl/predecode_lane.sv | 37 +++
 rtl/fetch_predecode_bundle.sv | 95 +++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared opcode constants and the per-lane predecode record used by the
// fetch-stage predecoder.
package fetch_pkg;

  localparam logic [4:0] OP_BRANCH = 5'b11000;
  localparam logic [4:0] OP_JAL    = 5'b11011;
  localparam logic [4:0] OP_JALR   = 5'b11001;

  localparam int INST_W = 32;

  // imm is kept at instruction width; the top sign-extends it to XLEN.
  typedef struct packed {
    logic              is_br;
    logic              is_jal;
    logic              is_jalr;
    logic              pred_taken;
    logic [INST_W-1:0] imm;
  } predecode_t;

endpackage

// File: rtl/fetch_predecode_bundle_if.sv
// Fetch-to-decode bundle bus: fetch-side handshake, decode-side handshake,
// flush, and the redirect toward the PC generator.
interface fetch_predecode_bundle_if #(
  parameter int LANES = 2,
  parameter int XLEN  = 32
);

  logic                   flush;
  logic                   in_valid;
  logic                   in_ready;
  logic [XLEN-1:0]        in_pc;
  logic [32*LANES-1:0]    in_inst;
  logic [LANES-1:0]       in_lane_valid;

  logic                   out_valid;
  logic                   out_ready;
  logic [XLEN-1:0]        out_pc;
  logic [32*LANES-1:0]    out_inst;
  logic [LANES-1:0]       out_lane_valid;
  logic [LANES-1:0]       out_is_br;
  logic [LANES-1:0]       out_is_jal;
  logic [LANES-1:0]       out_is_jalr;
  logic [LANES-1:0]       out_pred_taken;
  logic [XLEN*LANES-1:0]  out_imm;

  logic                   redirect_valid;
  logic [XLEN-1:0]        redirect_pc;

  modport master (
    output flush, in_valid, in_pc, in_inst, in_lane_valid, out_ready,
    input  in_ready, out_valid, out_pc, out_inst, out_lane_valid,
           out_is_br, out_is_jal, out_is_jalr, out_pred_taken, out_imm,
           redirect_valid, redirect_pc
  );

  modport slave (
    input  flush, in_valid, in_pc, in_inst, in_lane_valid, out_ready,
    output in_ready, out_valid, out_pc, out_inst, out_lane_valid,
           out_is_br, out_is_jal, out_is_jalr, out_pred_taken, out_imm,
           redirect_valid, redirect_pc
  );

endinterface

// File: rtl/predecode_lane.sv
// Single-lane classifier: flags control-flow instructions, extracts the
// sign-extended immediate and applies static backward-taken prediction.
module predecode_lane
  import fetch_pkg::*;
(
  input  logic [31:0] inst,
  input  logic        lane_valid,
  output predecode_t  pd
);

  // The two low opcode bits are always 2'b11 for 32-bit encodings.
  logic unused_lsbs;
  assign unused_lsbs = ^inst[1:0];

  always_comb begin
    // NOTE: default the whole record first so no path through the case infers a latch.
    pd = '0;
    case (inst[6:2])
      OP_BRANCH: begin
        pd.imm        = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
        pd.is_br      = lane_valid;
        pd.pred_taken = lane_valid && inst[31];
      end
      OP_JAL: begin
        pd.imm        = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
        pd.is_jal     = lane_valid;
        pd.pred_taken = lane_valid;
      end
      OP_JALR: begin
        pd.imm        = {{20{inst[31]}}, inst[31:20]};
        pd.is_jalr    = lane_valid;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/fetch_predecode_bundle.sv
// Fetch-stage predecoder: classifies every lane, truncates after the first
// predicted-taken lane, registers the bundle and emits a one-shot redirect.
module fetch_predecode_bundle
  import fetch_pkg::*;
#(
  parameter int LANES = 2,
  parameter int XLEN  = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  fetch_predecode_bundle_if.slave  bus
);

  predecode_t            pd [LANES];
  logic [LANES-1:0]      br_v, jal_v, jalr_v, taken_v, keep_mask;
  logic [XLEN*LANES-1:0] imm_v;
  logic                  seen, taken_any, in_fire, redirect_sent;
  logic [XLEN-1:0]       k_off, k_imm, target;

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    predecode_lane u_lane (
      .inst       (bus.in_inst[32*g +: 32]),
      .lane_valid (bus.in_lane_valid[g]),
      .pd         (pd[g])
    );
    assign br_v[g]    = pd[g].is_br;
    assign jal_v[g]   = pd[g].is_jal;
    assign jalr_v[g]  = pd[g].is_jalr;
    assign taken_v[g] = pd[g].pred_taken;
    assign imm_v[XLEN*g +: XLEN] = XLEN'($signed(pd[g].imm));
  end

  // Lowest taken lane wins; every lane at or below it survives truncation.
  always_comb begin
    seen      = 1'b0;
    keep_mask = '0;
    k_off     = '0;
    k_imm     = '0;
    for (int i = 0; i < LANES; i++) begin
      keep_mask[i] = !seen;
      if (taken_v[i] && !seen) begin
        k_off = XLEN'(4 * i);
        k_imm = imm_v[XLEN*i +: XLEN];
      end
      seen = seen | taken_v[i];
    end
    taken_any = seen;
  end

  assign target       = bus.in_pc + k_off + k_imm;
  assign bus.in_ready = !rst && !bus.flush && (!bus.out_valid || bus.out_ready);
  assign in_fire      = bus.in_valid && bus.in_ready;

  // Redirect fires only in the first visible cycle of a taken bundle.
  assign bus.redirect_valid = bus.out_valid && (|bus.out_pred_taken) && !redirect_sent;

  // NOTE: non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the datapath registers are reset too so the bundle reads all-zero out of reset.
      bus.out_valid      <= 1'b0;
      redirect_sent      <= 1'b0;
      bus.out_pc         <= '0;
      bus.out_inst       <= '0;
      bus.out_lane_valid <= '0;
      bus.out_is_br      <= '0;
      bus.out_is_jal     <= '0;
      bus.out_is_jalr    <= '0;
      bus.out_pred_taken <= '0;
      bus.out_imm        <= '0;
      bus.redirect_pc    <= '0;
    end else if (bus.flush) begin
      bus.out_valid <= 1'b0;
      redirect_sent <= 1'b0;
    end else if (in_fire) begin
      bus.out_valid      <= 1'b1;
      redirect_sent      <= 1'b0;
      bus.out_pc         <= bus.in_pc;
      bus.out_inst       <= bus.in_inst;
      bus.out_lane_valid <= bus.in_lane_valid & keep_mask;
      bus.out_is_br      <= br_v;
      bus.out_is_jal     <= jal_v;
      bus.out_is_jalr    <= jalr_v;
      bus.out_pred_taken <= taken_v & keep_mask;
      bus.out_imm        <= imm_v;
      if (taken_any) bus.redirect_pc <= target;
    end else if (bus.out_ready) begin
      bus.out_valid <= 1'b0;
      redirect_sent <= 1'b0;
    end else if (bus.redirect_valid) begin
      redirect_sent <= 1'b1;
    end
  end

endmodule
